fib_hex_monitor: RTL and testbench

Receive-side checker for the three-digit seven-segment Fibonacci display bus. It watches the HEX2/HEX1/HEX0 segment patterns driven by the Fibonacci generator and waits for each new pattern to settle. It then decodes the settled pattern back to a binary value and checks it against an internally generated Fibonacci sequence. It sits beside the generator on the same clock, as a self-check block for the board and as a scoreboard for simulation.

---
 rtl/fib_hex_monitor.sv | 190 +++++++++++++++++++
 tb/tb_fib_hex_monitor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fib_hex_monitor.sv
// fib_hex_monitor: waits for the HEX2..HEX0 segment bundle to settle, decodes it
// and checks the value against an internally tracked Fibonacci sequence.
module fib_hex_monitor #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] HEX0,
  input  logic [6:0] HEX1,
  input  logic [6:0] HEX2,
  output logic [9:0] value,
  output logic       value_valid,
  output logic       match,
  output logic       mismatch,
  output logic       illegal,
  output logic       locked,
  output logic       ovf,
  output logic [7:0] err_count
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_N = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    C_BLANK  = 4'd10;
  localparam logic [3:0]    C_E      = 4'd11;
  localparam logic [3:0]    C_BAD    = 4'd15;

  typedef enum logic [1:0] {S_SYNC = 2'd0, S_TRACK = 2'd1, S_OVF = 2'd2} state_t;

  function automatic logic [3:0] seg_code(input logic [6:0] seg);
    case (seg)
      7'b1000000: seg_code = 4'd0;
      7'b1111001: seg_code = 4'd1;
      7'b0100100: seg_code = 4'd2;
      7'b0110000: seg_code = 4'd3;
      7'b0011001: seg_code = 4'd4;
      7'b0010010: seg_code = 4'd5;
      7'b0000010: seg_code = 4'd6;
      7'b1111000: seg_code = 4'd7;
      7'b0000000: seg_code = 4'd8;
      7'b0010000: seg_code = 4'd9;
      7'b1111111: seg_code = C_BLANK;
      7'b0000110: seg_code = C_E;
      default:    seg_code = C_BAD;
    endcase
  endfunction

  logic [20:0]   w_bundle, r_prev, r_last_acc;
  logic [CW-1:0] r_cnt, w_run;
  logic          w_accept;
  logic [3:0]    w_c0, w_c1, w_c2, w_n0, w_n1, w_n2;
  logic          w_dig0, w_dig1, w_dig2, w_blk1, w_blk2, w_eee, w_legal, w_illegal;
  logic [9:0]    w_dec;

  state_t     r_state, w_state_nxt;
  logic [9:0] r_a, r_b, w_a_nxt, w_b_nxt, r_value, w_value_nxt;
  logic [7:0] r_err, w_err_nxt;
  logic       w_match_nxt, w_mm_nxt;
  logic       r_vv, r_match, r_mm, r_ill, r_locked, r_ovf;

  assign w_bundle = {HEX2, HEX1, HEX0};
  // Run length includes the current cycle; a new bundle restarts it at one.
  assign w_run    = (w_bundle != r_prev) ? CNT_ONE :
                    ((r_cnt == STABLE_N) ? r_cnt : r_cnt + CNT_ONE);
  assign w_accept = (w_run == STABLE_N) && (w_bundle != r_last_acc);

  assign w_c0   = seg_code(HEX0);
  assign w_c1   = seg_code(HEX1);
  assign w_c2   = seg_code(HEX2);
  assign w_dig0 = (w_c0 <= 4'd9);
  assign w_dig1 = (w_c1 <= 4'd9);
  assign w_dig2 = (w_c2 <= 4'd9);
  assign w_blk1 = (w_c1 == C_BLANK);
  assign w_blk2 = (w_c2 == C_BLANK);
  assign w_eee  = (w_c0 == C_E) && (w_c1 == C_E) && (w_c2 == C_E);
  assign w_legal = w_dig0 && (w_dig1 || w_blk1) && (w_dig2 || w_blk2) &&
                   !(w_blk1 && !w_blk2) &&
                   !(w_dig2 && (w_c2 == 4'd0)) &&
                   !(w_blk2 && w_dig1 && (w_c1 == 4'd0));
  assign w_illegal = !w_legal && !w_eee;
  assign w_n0  = w_dig0 ? w_c0 : 4'd0;
  assign w_n1  = w_dig1 ? w_c1 : 4'd0;
  assign w_n2  = w_dig2 ? w_c2 : 4'd0;
  assign w_dec = 10'(w_n2) * 10'd100 + 10'(w_n1) * 10'd10 + 10'(w_n0);

  // Stability tracker and last accepted bundle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev     <= {21{1'b1}};
      r_cnt      <= '0;
      r_last_acc <= {21{1'b1}};
    end else begin
      r_prev <= w_bundle;
      r_cnt  <= w_run;
      if (w_accept) begin
        r_last_acc <= w_bundle;
      end else begin
        r_last_acc <= r_last_acc;
      end
    end
  end

  // Next-state and compare logic evaluated on each accepted bundle.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_value_nxt = r_value;
    w_err_nxt   = r_err;
    w_match_nxt = 1'b0;
    w_mm_nxt    = 1'b0;
    if (w_accept) begin
      if (w_legal) begin
        w_value_nxt = w_dec;
      end else begin
        w_value_nxt = r_value;
      end
      if (w_legal && (w_dec == 10'd0)) begin
        w_state_nxt = S_TRACK;
        w_a_nxt     = 10'd1;
        w_b_nxt     = 10'd1;
      end else begin
        case (r_state)
          S_TRACK: begin
            if (w_legal && (w_dec == r_a)) begin
              w_match_nxt = 1'b1;
              // a==b only on the repeated 1, so skip a full step ahead.
              if (w_dec == r_b) begin
                w_a_nxt = r_a + r_b;
                w_b_nxt = r_a + {r_b[8:0], 1'b0};
              end else begin
                w_a_nxt = r_b;
                w_b_nxt = r_a + r_b;
              end
            end else if (w_eee && (r_a > 10'd255)) begin
              w_match_nxt = 1'b1;
              w_state_nxt = S_OVF;
            end else begin
              w_mm_nxt    = 1'b1;
              w_err_nxt   = (r_err == 8'd255) ? r_err : r_err + 8'd1;
              w_state_nxt = S_SYNC;
            end
          end
          S_SYNC:  w_state_nxt = S_SYNC;
          S_OVF:   w_state_nxt = S_OVF;
          default: w_state_nxt = S_SYNC;
        endcase
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, expected pair and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_SYNC;
      r_a      <= 10'd0;
      r_b      <= 10'd0;
      r_value  <= 10'd0;
      r_err    <= 8'd0;
      r_vv     <= 1'b0;
      r_match  <= 1'b0;
      r_mm     <= 1'b0;
      r_ill    <= 1'b0;
      r_locked <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_value  <= w_value_nxt;
      r_err    <= w_err_nxt;
      r_vv     <= w_accept;
      r_match  <= w_match_nxt;
      r_mm     <= w_mm_nxt;
      r_ill    <= w_accept && w_illegal;
      r_locked <= (w_state_nxt == S_TRACK);
      r_ovf    <= (w_state_nxt == S_OVF);
    end
  end

  assign value       = r_value;
  assign value_valid = r_vv;
  assign match       = r_match;
  assign mismatch    = r_mm;
  assign illegal     = r_ill;
  assign locked      = r_locked;
  assign ovf         = r_ovf;
  assign err_count   = r_err;
endmodule

// File: tb/tb_fib_hex_monitor.sv
// Testbench for fib_hex_monitor: directed and random segment bundles checked
// against a transaction-level model built on a Fibonacci index.
module tb_fib_hex_monitor;
  localparam int S = 4;
  localparam logic [20:0] BLANK3 = {3{7'b1111111}};
  localparam logic [20:0] EEE3   = {3{7'b0000110}};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] hex0 = 7'h7F, hex1 = 7'h7F, hex2 = 7'h7F;
  logic [9:0] value;
  logic       value_valid, match, mismatch, illegal, locked, ovf;
  logic [7:0] err_count;

  int tests = 0;
  int fails = 0;
  logic [6:0] seg_tab [0:9];
  int seq [0:19];
  int m_state, m_k, m_value, m_err;
  logic [20:0] m_last;
  int e_vv, e_match, e_mm, e_ill;

  fib_hex_monitor #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .HEX0(hex0), .HEX1(hex1), .HEX2(hex2),
    .value(value), .value_valid(value_valid), .match(match), .mismatch(mismatch),
    .illegal(illegal), .locked(locked), .ovf(ovf), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dig(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (s == seg_tab[i]) return i;
    if (s == 7'b1111111) return 10;
    if (s == 7'b0000110) return 11;
    return -1;
  endfunction

  function automatic logic [20:0] num_bundle(input int n);
    logic [6:0] h2, h1, h0;
    h2 = (n >= 100) ? seg_tab[n / 100] : 7'b1111111;
    h1 = (n >= 10) ? seg_tab[(n / 10) % 10] : 7'b1111111;
    h0 = seg_tab[n % 10];
    return {h2, h1, h0};
  endfunction

  task automatic model_reset();
    m_state = 0; m_k = 0; m_value = 0; m_err = 0; m_last = BLANK3;
  endtask

  // Model: state 0=SYNC 1=TRACK 2=OVF; in TRACK the expected value is seq[m_k].
  task automatic model_step(input logic [20:0] b);
    int d2, d1, d0, dec;
    bit legal, eee;
    d2 = dig(b[20:14]); d1 = dig(b[13:7]); d0 = dig(b[6:0]);
    eee = (d2 == 11) && (d1 == 11) && (d0 == 11);
    legal = (d0 >= 0 && d0 <= 9) && (d1 >= 0 && d1 <= 10) && (d2 >= 0 && d2 <= 10)
            && !(d1 == 10 && d2 != 10) && (d2 != 0) && !(d2 == 10 && d1 == 0);
    dec = (d2 < 10 ? d2 : 0) * 100 + (d1 < 10 ? d1 : 0) * 10 + d0;
    e_vv = 0; e_match = 0; e_mm = 0; e_ill = 0;
    if (b != m_last) begin
      m_last = b;
      e_vv = 1;
      e_ill = (!legal && !eee) ? 1 : 0;
      if (legal) m_value = dec;
      if (legal && dec == 0) begin
        m_state = 1; m_k = 0;
      end else if (m_state == 1) begin
        if (legal && dec == seq[m_k]) begin
          e_match = 1;
          if (m_k < 19) m_k++;
        end else if (eee && seq[m_k] > 255) begin
          e_match = 1; m_state = 2;
        end else begin
          e_mm = 1; m_state = 0;
          if (m_err < 255) m_err++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".value"}, value, m_value);
    check({tag, ".value_valid"}, value_valid, e_vv);
    check({tag, ".match"}, match, e_match);
    check({tag, ".mismatch"}, mismatch, e_mm);
    check({tag, ".illegal"}, illegal, e_ill);
    check({tag, ".locked"}, locked, (m_state == 1) ? 1 : 0);
    check({tag, ".ovf"}, ovf, (m_state == 2) ? 1 : 0);
    check({tag, ".err_count"}, err_count, m_err);
  endtask

  task automatic apply(input logic [20:0] b, input string tag);
    @(negedge clk);
    {hex2, hex1, hex0} = b;
    model_step(b);
    repeat (S - 1) @(negedge clk);
    check({tag, ".early"}, value_valid, 0);
    @(negedge clk);
    check_all(tag);
    @(negedge clk);
    check({tag, ".one_shot"}, {value_valid, match, mismatch, illegal}, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_fib(input string tag);
    int f [0:12];
    f = '{0, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    for (int i = 0; i < 13; i++) apply(num_bundle(f[i]), tag);
    apply(EEE3, {tag, ".eee"});
  endtask

  function automatic logic [20:0] rand_bundle();
    int kind;
    kind = $urandom_range(0, 9);
    case (kind)
      0, 1, 2, 3: return num_bundle((m_state == 1 && seq[m_k] <= 999) ? seq[m_k]
                                                                      : $urandom_range(0, 999));
      4: return num_bundle(0);
      5: return num_bundle($urandom_range(0, 999));
      6: return EEE3;
      7: return {seg_tab[$urandom_range(1, 9)], 7'b1111111, seg_tab[$urandom_range(0, 9)]};
      8: return {7'b1111111, seg_tab[0], seg_tab[$urandom_range(0, 9)]};
      default: return 21'($urandom());
    endcase
  endfunction

  initial begin
    logic [20:0] b;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    seq[0] = 1; seq[1] = 2;
    for (int i = 2; i < 20; i++) seq[i] = (seq[i-1] + seq[i-2]) % 1024;
    model_reset();
    e_vv = 0; e_match = 0; e_mm = 0; e_ill = 0;

    repeat (3) @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    run_fib("fib");

    apply(num_bundle(0), "mm.0");
    apply(num_bundle(1), "mm.1");
    apply(num_bundle(2), "mm.2");
    apply(num_bundle(3), "mm.3");
    apply(num_bundle(4), "mm.4");
    apply(num_bundle(0), "mm.relock");

    apply(num_bundle(1), "ill.1");
    apply({seg_tab[1], 7'b1111111, seg_tab[5]}, "ill.b15");

    apply(num_bundle(0), "gl.0");
    apply(num_bundle(1), "gl.1");
    apply(num_bundle(2), "gl.2");
    @(negedge clk);
    {hex2, hex1, hex0} = num_bundle(3);
    repeat (3) @(negedge clk);
    {hex2, hex1, hex0} = num_bundle(2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("glitch.value_valid", value_valid, 0);
    end
    e_vv = 0; e_match = 0; e_mm = 0; e_ill = 0;
    check_all("glitch.after");

    for (int i = 0; i < 80; i++) begin
      b = rand_bundle();
      apply(b, "rand");
    end

    for (int i = 0; i < 260; i++) begin
      apply(num_bundle(0), "sat.0");
      apply(num_bundle(7), "sat.7");
    end
    check("sat.final", err_count, 255);

    @(negedge clk);
    reset = 1'b1;
    {hex2, hex1, hex0} = BLANK3;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply(num_bundle(0), "r5.0");
      apply(num_bundle(7), "r5.7");
    end
    run_fib("r5fib");
    check("r5.err", err_count, 5);
    check("r5.ovf", ovf, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async.zero", {value, value_valid, match, mismatch, illegal, locked, ovf, err_count}, 0);
    {hex2, hex1, hex0} = BLANK3;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    apply(num_bundle(1), "post.1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
